// File: rtl/example_and_unit_if.sv
// Purpose: operand/result bundle for example_and_unit.
//   master: drives raw operands and count clear, observes result, pulses, count.
//   slave : the AND unit itself.
interface example_and_unit_if #(
    parameter int unsigned COUNT_WIDTH = 8
);
    logic                   input_1;
    logic                   input_2;
    logic                   count_clr;
    logic                   and_result;
    logic                   rise_pulse;
    logic                   fall_pulse;
    logic [COUNT_WIDTH-1:0] assert_count;

    modport master (
        output input_1,
        output input_2,
        output count_clr,
        input  and_result,
        input  rise_pulse,
        input  fall_pulse,
        input  assert_count
    );

    modport slave (
        input  input_1,
        input  input_2,
        input  count_clr,
        output and_result,
        output rise_pulse,
        output fall_pulse,
        output assert_count
    );
endinterface

// File: rtl/example_and_unit.sv
// Purpose: registered, glitch-filtered two-input AND for board-level inputs.
//   Each raw operand is synchronised (two flops), debounced over
//   DEBOUNCE_CYCLES stable cycles, then ANDed into a registered result.
//   Also emits one-cycle rise/fall pulses and a saturating rise count.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of example_and_unit_if (input_1, input_2, count_clr in;
//           and_result, rise_pulse, fall_pulse, assert_count out)
module example_and_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    example_and_unit_if.slave bus
);

    localparam int unsigned     N_IN      = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [N_IN-1:0]            raw;
    logic [N_IN-1:0]            s1_q, s1_d;
    logic [N_IN-1:0]            s2_q, s2_d;
    logic [N_IN-1:0]            filt_q, filt_d;
    logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                       and_q, and_d;
    logic                       rise_q, rise_d;
    logic                       fall_q, fall_d;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;

    assign raw = {bus.input_2, bus.input_1};

    // Synchronise, debounce, combine, detect edges and count rises.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        count_d = count_q;

        // Any return to the filtered value restarts the stability count.
        for (int i = 0; i < int'(N_IN); i++) begin
            if (s2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        and_d  = &filt_q;
        rise_d = and_d & ~and_q;
        fall_d = ~and_d & and_q;

        // Count follows the rise pulse by one cycle; clear beats increment.
        if (bus.count_clr) begin
            count_d = '0;
        end else if (rise_q && (count_q != COUNT_MAX)) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // State registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            and_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            and_q   <= and_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    assign bus.and_result   = and_q;
    assign bus.rise_pulse   = rise_q;
    assign bus.fall_pulse   = fall_q;
    assign bus.assert_count = count_q;

endmodule

// File: tb/tb_example_and_unit.sv
// Bench for example_and_unit: two instances (D=4/8-bit count, D=1/2-bit count)
// share stimulus and are compared every cycle against a window-based model.
module tb_example_and_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b1;
    logic in2 = 1'b1;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    example_and_unit_if #(.COUNT_WIDTH(8)) bus0 ();
    example_and_unit_if #(.COUNT_WIDTH(2)) bus1 ();

    assign bus0.input_1   = in1;
    assign bus0.input_2   = in2;
    assign bus0.count_clr = clr;
    assign bus1.input_1   = in1;
    assign bus1.input_2   = in2;
    assign bus1.count_clr = clr;

    example_and_unit #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .COUNT_WIDTH(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    example_and_unit #(.DEBOUNCE_CYCLES(1), .CNT_W(4), .COUNT_WIDTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A filtered input flips when the last D synchronised samples all differ
    // from its current value.
    int  dcyc [2] = '{4, 1};
    int  cmax [2] = '{255, 3};
    bit  ms1  [2][2];
    bit  ms2  [2][2];
    bit  mf   [2][2];
    bit  win  [2][2][$];
    bit  mres [2];
    bit  mrise[2];
    bit  mfall[2];
    int  mcnt [2];

    always @(posedge clk) begin
        bit in_v[2];
        bit old_f[2];
        bit old_res, old_rise, all_diff, new_res;
        in_v[0] = in1;
        in_v[1] = in2;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int j = 0; j < 2; j++) begin
                    ms1[i][j] = 1'b0;
                    ms2[i][j] = 1'b0;
                    mf[i][j]  = 1'b0;
                    win[i][j].delete();
                end
                mres[i]  = 1'b0;
                mrise[i] = 1'b0;
                mfall[i] = 1'b0;
                mcnt[i]  = 0;
            end else begin
                old_f[0] = mf[i][0];
                old_f[1] = mf[i][1];
                old_res  = mres[i];
                old_rise = mrise[i];
                for (int j = 0; j < 2; j++) begin
                    win[i][j].push_back(ms2[i][j]);
                    if (win[i][j].size() > dcyc[i]) void'(win[i][j].pop_front());
                    if (win[i][j].size() == dcyc[i]) begin
                        all_diff = 1'b1;
                        foreach (win[i][j][k]) if (win[i][j][k] == mf[i][j]) all_diff = 1'b0;
                        if (all_diff) mf[i][j] = ~mf[i][j];
                    end
                    ms2[i][j] = ms1[i][j];
                    ms1[i][j] = in_v[j];
                end
                new_res  = old_f[0] & old_f[1];
                mrise[i] = new_res & ~old_res;
                mfall[i] = ~new_res & old_res;
                mres[i]  = new_res;
                if (clr) mcnt[i] = 0;
                else if (old_rise && mcnt[i] < cmax[i]) mcnt[i]++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;
    int rise_seen0 = 0;
    int fall_seen0 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d0.and_result", int'(bus0.and_result), int'(mres[0]));
            chk("d0.rise_pulse", int'(bus0.rise_pulse), int'(mrise[0]));
            chk("d0.fall_pulse", int'(bus0.fall_pulse), int'(mfall[0]));
            chk("d0.assert_count", int'(bus0.assert_count), mcnt[0]);
            chk("d1.and_result", int'(bus1.and_result), int'(mres[1]));
            chk("d1.rise_pulse", int'(bus1.rise_pulse), int'(mrise[1]));
            chk("d1.fall_pulse", int'(bus1.fall_pulse), int'(mfall[1]));
            chk("d1.assert_count", int'(bus1.assert_count), mcnt[1]);
            chk("d0.pulse_exclusive", int'(bus0.rise_pulse & bus0.fall_pulse), 0);
            if (bus0.rise_pulse) rise_seen0++;
            if (bus0.fall_pulse) fall_seen0++;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release or input change happened just before; check d0 over 7 edges.
    task automatic check_latency7(input string nm);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk({nm, ".and_result"}, int'(bus0.and_result), (k == 7) ? 1 : 0);
        end
    endtask

    int r0, f0;
    bit ri1, ri2;

    initial begin
        // Reset with inputs high: outputs stay 0.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst.and_result", int'(bus0.and_result), 0);
            chk("rst.assert_count", int'(bus0.assert_count), 0);
        end
        rst_n = 1'b1;
        check_latency7("release");
        chk("release.rise_pulse", int'(bus0.rise_pulse), 1);
        @(posedge clk);
        #1;
        chk("release.rise_gone", int'(bus0.rise_pulse), 0);
        chk("release.assert_count", int'(bus0.assert_count), 1);

        // Truth table.
        @(negedge clk);
        in1 = 1'b0; in2 = 1'b0;
        hold(10);
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        hold(10);
        r0 = rise_seen0;
        f0 = fall_seen0;
        begin
            bit a_tab[6] = '{0, 1, 1, 0, 0, 1};
            bit b_tab[6] = '{0, 0, 1, 1, 0, 1};
            int e_tab[6] = '{0, 0, 1, 0, 0, 1};
            for (int s = 0; s < 6; s++) begin
                in1 = a_tab[s];
                in2 = b_tab[s];
                hold(20);
                chk($sformatf("tt%0d.and_result", s), int'(bus0.and_result), e_tab[s]);
            end
        end
        chk("tt.rises", rise_seen0 - r0, 2);
        chk("tt.falls", fall_seen0 - f0, 1);
        chk("tt.assert_count", int'(bus0.assert_count), 2);

        // Glitch rejection on input_1.
        in1 = 1'b0; in2 = 1'b1;
        hold(20);
        r0 = rise_seen0;
        f0 = fall_seen0;
        in1 = 1'b1; hold(3);
        in1 = 1'b0; hold(20);
        chk("glitch3.and_result", int'(bus0.and_result), 0);
        chk("glitch3.rises", rise_seen0 - r0, 0);
        chk("glitch3.falls", fall_seen0 - f0, 0);
        in1 = 1'b1; hold(4);
        in1 = 1'b0; hold(20);
        chk("glitch4.rises", rise_seen0 - r0, 1);
        chk("glitch4.falls", fall_seen0 - f0, 1);
        chk("glitch4.and_result", int'(bus0.and_result), 0);

        // Latency: input_2 rises before edge E, result first 1 after E+6.
        in1 = 1'b1; in2 = 1'b0;
        hold(20);
        in2 = 1'b1;
        check_latency7("latency");

        // Saturating 2-bit counter on d1.
        @(negedge clk);
        in1 = 1'b0; in2 = 1'b1;
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in1 = 1'b0; hold(10);
            in1 = 1'b1; hold(10);
            chk($sformatf("sat%0d.assert_count", k), int'(bus1.assert_count), (k < 3) ? k : 3);
        end
        in1 = 1'b0; hold(10);
        clr = 1'b1;
        in1 = 1'b1; hold(10);
        clr = 1'b0;
        hold(2);
        chk("clr_vs_rise.d1_count", int'(bus1.assert_count), 0);
        chk("clr_vs_rise.d0_count", int'(bus0.assert_count), 0);

        // Reset mid-debounce restarts full latency.
        in1 = 1'b0; in2 = 1'b0;
        hold(20);
        in1 = 1'b1; in2 = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        hold(2);
        chk("midrst.and_result", int'(bus0.and_result), 0);
        rst_n = 1'b1;
        check_latency7("midrst");

        // Randomised segments.
        @(negedge clk);
        repeat (250) begin
            ri1 = 1'($urandom_range(0, 1));
            ri2 = 1'($urandom_range(0, 1));
            in1 = ri1;
            in2 = ri2;
            rst_n = ($urandom_range(0, 39) != 0);
            repeat ($urandom_range(1, 8)) begin
                clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        clr = 1'b0;
        hold(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
